rr_arbiter_8: RTL and testbench
===============================

Name: rr_arbiter_8

Overview:
- Registered round-robin arbiter for 8 requesters.
- Produces a strictly one-hot (or all-zero) grant vector.
- The grant vector drives the one-hot 8-to-3 encoder directly downstream, which converts it to a 3-bit index for the datapath mux.
- Holds each grant until the owner releases it or a hold-timeout expires. The downstream encoder therefore never sees a multi-hot input.

Parameters:
- N, 8, number of requesters; grant width. Only 8 is supported by the downstream encoder.
- MAX_HOLD, 16, maximum number of consecutive cycles a grant may be held before forced revocation. Range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i high means requester i wants the resource. Bits are level-sensitive.
- release  input  1  single-cycle pulse from the current owner ending its grant. Ignored when grant_valid=0.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  high when grant is non-zero; equals the OR of grant.
- timeout  output  1  single-cycle pulse on forced revocation.
- hold_cnt  output  8  cycles elapsed in the current grant. Starts at 0 in the first grant cycle.

Behaviour:
- Reset (rst high at a clk edge):
  - grant=0, grant_valid=0, timeout=0, hold_cnt=0.
  - State=IDLE.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - Reset overrides all other events, including mid-grant; the grant drops on the next edge.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap mod N).
  - Register the winner into grant at the next edge and go to GRANT. Latency: req sampled at edge t, grant visible after edge t.
  - hold_cnt=0 on entry.
  - If req==0, stay in IDLE with grant=0.
- GRANT:
  - grant holds constant. hold_cnt increments each cycle and saturates at 255.
  - Exit conditions, evaluated each edge in priority order:
    - (a) release=1 → IDLE.
    - (b) req[owner]=0, i.e. the owner dropped its request → IDLE.
    - (c) hold_cnt==MAX_HOLD-1 → IDLE with timeout=1 for exactly one cycle.
  - If release and the timeout condition coincide, release wins and timeout stays 0.
  - On any exit: grant=0, hold_cnt=0, ptr=(owner+1) mod N. If owner=7, ptr wraps to 0.
- Gap between grants: grant is all-zero for exactly one cycle after every exit, because IDLE re-arbitrates on the next edge. Back-to-back grants to different owners are separated by one idle cycle.
- Pointer update: ptr changes only on GRANT exit, never in IDLE.
- Request changes during GRANT: changes on non-owner req bits have no effect until the next arbitration.
- Invariant: grant is always one-hot or zero, and is never X after reset.
- Release in IDLE: no effect; timeout stays 0.

Test Plan:
- Reset then single requester: rst for 2 cycles, then req=8'b0000_0100 → grant=8'b0000_0100 one cycle after sampling. grant_valid=1 and hold_cnt=0 in the first grant cycle.
- Round-robin fairness: req=8'hFF held with a release pulse every 3rd grant cycle → successive grants are bits 0,1,2,…,7,0. Each grant is separated by exactly one all-zero cycle.
- Wrap-around priority: owner=6 releases while req=8'b0100_0001 → next grant is bit 0 (bit 7 absent, scan wraps to bit 0). ptr=7 at the time of that arbitration.
- Timeout, MAX_HOLD=4: req=8'b0001_0000 held, no release → grant lasts exactly 4 cycles (hold_cnt 0..3). timeout pulses once on the revoke edge, grant=0 for one cycle, then bit 4 is re-granted.
- Owner drop and simultaneous events: owner drops its req mid-grant → grant=0 next cycle and timeout=0. In a separate case, release and timeout coincide → grant revoked with timeout=0.
- Reset mid-grant: rst asserted while grant=8'b1000_0000 → grant=0 and hold_cnt=0 at the next edge. After rst deasserts with req=8'hFF, the first grant is bit 0 (ptr restored to 0).

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Registered round-robin arbiter for 8 requesters with hold timeout.
// A grant is one-hot or zero and is held until the owner releases it,
// drops its request, or holds it for MAX_HOLD cycles. After each exit
// the arbiter idles for one cycle before re-arbitrating.
module rr_arbiter_8 #(
   parameter int N        = 8,   // requesters; the downstream encoder supports 8 only
   parameter int MAX_HOLD = 16   // 1..255 cycles before forced revocation
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   // Owner's end-of-grant pulse; named release_i because 'release' is reserved.
   input  logic         release_i,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   output logic         timeout,
   output logic [7:0]   hold_cnt
);

   localparam int         IDX_W     = $clog2(N);
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_e;

   state_e             state_q, state_d;
   logic [N-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic               timeout_q, timeout_d;
   logic [7:0]         hold_cnt_q, hold_cnt_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic               grant_exit;

   // Find the first requester at or after ptr, wrapping modulo N.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      win_found = 1'b0;
      win_idx   = ptr_q;
      for (int i = 0; i < N; i++) begin
         if (!win_found && req[ptr_q + IDX_W'(i)]) begin
            win_found = 1'b1;
            win_idx   = ptr_q + IDX_W'(i);
         end
      end
   end

   // Next-state logic: arbitrate in IDLE, hold and watch exit conditions in GRANT.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      timeout_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;
      grant_exit = 1'b0;

      unique case (state_q)
         IDLE: begin
            grant_d    = '0;
            hold_cnt_d = 8'd0;
            if (win_found) begin
               state_d          = GRANT;
               owner_d          = win_idx;
               grant_d[win_idx] = 1'b1;
            end
         end

         GRANT: begin
            // Exit priority: release, then owner drop, then timeout.
            grant_exit = release_i || !req[owner_q] || (hold_cnt_q == HOLD_LAST);
            if (grant_exit) begin
               state_d    = IDLE;
               grant_d    = '0;
               hold_cnt_d = 8'd0;
               ptr_d      = owner_q + IDX_W'(1);
               // Timeout only reports a revocation nothing else explains.
               timeout_d  = !release_i && req[owner_q];
            end else if (hold_cnt_q != 8'hFF) begin
               hold_cnt_d = hold_cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers with synchronous reset that overrides any grant in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         state_q    <= IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         owner_q    <= '0;
         timeout_q  <= 1'b0;
         hold_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         timeout_q  <= timeout_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign timeout     = timeout_q;
   assign hold_cnt    = hold_cnt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 (MAX_HOLD=4). Each step drives inputs,
// queues the outputs expected after the next edge, and compares them.
module tb_rr_arbiter_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       release_i;
   logic [7:0] grant;
   logic       grant_valid;
   logic       timeout;
   logic [7:0] hold_cnt;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string      tag;
      logic [7:0] grant;
      logic       timeout;
      logic [7:0] hold;
   } exp_t;

   exp_t sb[$];

   rr_arbiter_8 #(.N(8), .MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .release_i   (release_i),
      .grant       (grant),
      .grant_valid (grant_valid),
      .timeout     (timeout),
      .hold_cnt    (hold_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, then compare after the edge.
   task automatic step(input logic r, input logic [7:0] q, input logic rel,
                       input logic [7:0] eg, input logic eto, input logic [7:0] eh,
                       input string tag);
      exp_t e;
      rst       = r;
      req       = q;
      release_i = rel;
      e.tag = tag; e.grant = eg; e.timeout = eto; e.hold = eh;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check({e.tag, ".grant"},       grant,             e.grant);
      check({e.tag, ".grant_valid"}, {7'd0, grant_valid}, {7'd0, |e.grant});
      check({e.tag, ".timeout"},     {7'd0, timeout},     {7'd0, e.timeout});
      check({e.tag, ".hold_cnt"},    hold_cnt,          e.hold);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, then single requester 2
      step(1, 8'h00, 0, 8'h00, 0, 8'd0, "reset1");
      step(1, 8'h00, 0, 8'h00, 0, 8'd0, "reset2");
      step(0, 8'h04, 0, 8'h04, 0, 8'd0, "single_g0");
      step(0, 8'h04, 0, 8'h04, 0, 8'd1, "single_g1");
      step(0, 8'h04, 1, 8'h00, 0, 8'd0, "single_rel");
      step(0, 8'h00, 0, 8'h00, 0, 8'd0, "idle");
      step(0, 8'h00, 1, 8'h00, 0, 8'd0, "rel_in_idle");

      // Round-robin fairness from ptr=0: release on the third grant cycle
      step(1, 8'h00, 0, 8'h00, 0, 8'd0, "reset3");
      for (int k = 0; k < 9; k++) begin
         logic [7:0] g;
         g = 8'h01 << (k % 8);
         step(0, 8'hFF, 0, g,     0, 8'd0, $sformatf("rr%0d_h0", k));
         step(0, 8'hFF, 0, g,     0, 8'd1, $sformatf("rr%0d_h1", k));
         step(0, 8'hFF, 0, g,     0, 8'd2, $sformatf("rr%0d_h2", k));
         step(0, 8'hFF, 1, 8'h00, 0, 8'd0, $sformatf("rr%0d_gap", k));
      end

      // Wrap-around: owner 6 releases, scan from 7 wraps to 0 (ptr now 1)
      step(0, 8'h40, 0, 8'h40, 0, 8'd0, "wrap_g6");
      step(0, 8'h41, 1, 8'h00, 0, 8'd0, "wrap_rel6");
      step(0, 8'h41, 0, 8'h01, 0, 8'd0, "wrap_g0");
      step(0, 8'h41, 1, 8'h00, 0, 8'd0, "wrap_rel0");

      // Timeout at MAX_HOLD=4; non-owner bits wiggle without effect (ptr now 1)
      step(0, 8'h10, 0, 8'h10, 0, 8'd0, "to_h0");
      step(0, 8'h13, 0, 8'h10, 0, 8'd1, "to_h1");
      step(0, 8'hFF, 0, 8'h10, 0, 8'd2, "to_h2");
      step(0, 8'h11, 0, 8'h10, 0, 8'd3, "to_h3");
      step(0, 8'h10, 0, 8'h00, 1, 8'd0, "to_revoke");
      step(0, 8'h10, 0, 8'h10, 0, 8'd0, "to_regrant");

      // Owner drops its request mid-grant
      step(0, 8'h10, 0, 8'h10, 0, 8'd1, "drop_h1");
      step(0, 8'h00, 0, 8'h00, 0, 8'd0, "drop_exit");

      // Release coincides with timeout condition: release wins
      step(0, 8'h10, 0, 8'h10, 0, 8'd0, "rt_h0");
      step(0, 8'h10, 0, 8'h10, 0, 8'd1, "rt_h1");
      step(0, 8'h10, 0, 8'h10, 0, 8'd2, "rt_h2");
      step(0, 8'h10, 0, 8'h10, 0, 8'd3, "rt_h3");
      step(0, 8'h10, 1, 8'h00, 0, 8'd0, "rt_exit");
      step(0, 8'h00, 0, 8'h00, 0, 8'd0, "rt_idle");

      // Reset mid-grant on requester 7, then ptr restarts at 0
      step(0, 8'h80, 0, 8'h80, 0, 8'd0, "rm_g7");
      step(0, 8'h80, 0, 8'h80, 0, 8'd1, "rm_h1");
      step(1, 8'hFF, 0, 8'h00, 0, 8'd0, "rm_reset");
      step(0, 8'hFF, 0, 8'h01, 0, 8'd0, "rm_first");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
